// File: rtl/byte_word_packer.sv
// Packs a byte-wide valid/ready stream into LANES-wide little-endian words,
// with early flush on in_last and a per-lane keep mask.
module byte_word_packer #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [DATA_W*LANES-1:0]   out_data,
  output logic [LANES-1:0]          out_keep,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int CNT_W  = $clog2(LANES);
  localparam int WORD_W = DATA_W * LANES;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [LANES-1:0]  keep_q, keep_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic [LANES-1:0]  out_keep_q, out_keep_d;
  logic              out_last_q, out_last_d;
  logic              out_valid_q, out_valid_d;

  logic              in_ready_s;
  logic              accept_s;
  logic              close_s;
  logic [WORD_W-1:0] merged_data_s;
  logic [LANES-1:0]  merged_keep_s;

  // The output slot frees up either when empty or when being drained this cycle.
  assign in_ready_s = !out_valid_q || out_ready;
  assign in_ready   = in_ready_s;

  // Incoming byte merged into the current assembly word at lane cnt.
  always_comb begin
    merged_data_s = '0;
    merged_keep_s = '0;
    for (int k = 0; k < LANES; k++) begin
      merged_data_s[k*DATA_W +: DATA_W] = (cnt_q == CNT_W'(k)) ? in_data
                                                               : asm_q[k*DATA_W +: DATA_W];
      merged_keep_s[k] = (cnt_q == CNT_W'(k)) ? 1'b1 : keep_q[k];
    end
  end

  // Accept/close decisions and next-state for assembly and output registers.
  always_comb begin
    accept_s    = in_valid && in_ready_s;
    close_s     = accept_s && ((cnt_q == CNT_W'(LANES-1)) || in_last);
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    keep_d      = keep_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (close_s) begin
      // A close on the same edge as a consume simply overwrites the old word.
      out_data_d  = merged_data_s;
      out_keep_d  = merged_keep_s;
      out_last_d  = in_last;
      out_valid_d = 1'b1;
      cnt_d       = '0;
      asm_d       = '0;
      keep_d      = '0;
    end else if (accept_s) begin
      cnt_d  = cnt_q + CNT_W'(1);
      asm_d  = merged_data_s;
      keep_d = merged_keep_s;
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; reset discards any partial word and the pending output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      asm_q       <= '0;
      keep_q      <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      keep_q      <= keep_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed-vector bench for byte_word_packer with hand-computed expected words.
module tb_byte_word_packer;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  int n_vec  = 0;
  int n_miss = 0;

  byte_word_packer #(.DATA_W(8), .LANES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] d, input logic [3:0] k,
                          input logic l);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"},  out_data, d);
    chk({tag, "_keep"},  {28'd0, out_keep}, {28'd0, k});
    chk({tag, "_last"},  {31'd0, out_last}, {31'd0, l});
  endtask

  logic [31:0] stream_exp [4];

  initial begin
    stream_exp[0] = 32'h03020100;
    stream_exp[1] = 32'h07060504;
    stream_exp[2] = 32'h0B0A0908;
    stream_exp[3] = 32'h0F0E0D0C;

    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_keep", {28'd0, out_keep}, 32'd0);
    idle(3);
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_ready", {31'd0, in_ready}, 32'd1);

    // Full word
    push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0);
    chk("full_novalid", {31'd0, out_valid}, 32'd0);
    push(8'h44, 1'b0);
    chk_word("full", 32'h44332211, 4'b1111, 1'b0);
    idle(1);
    chk("full_onecycle", {31'd0, out_valid}, 32'd0);

    // Partial flush, then next word restarts at lane 0
    push(8'hA1, 1'b0); push(8'hB2, 1'b1);
    chk_word("flush", 32'h0000B2A1, 4'b0011, 1'b1);
    push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0); push(8'h04, 1'b0);
    chk_word("after_flush", 32'h04030201, 4'b1111, 1'b0);
    idle(1);

    // in_last on first byte, on last lane, and a bubble inside a word
    push(8'hAB, 1'b1);
    chk_word("last_first", 32'h000000AB, 4'b0001, 1'b1);
    push(8'h05, 1'b0); push(8'h06, 1'b0); push(8'h07, 1'b0); push(8'h08, 1'b1);
    chk_word("last_full", 32'h08070605, 4'b1111, 1'b1);
    push(8'hC1, 1'b0);
    in_data = 8'hEE; in_last = 1'b1;
    idle(2);
    push(8'hC2, 1'b1);
    chk_word("bubble", 32'h0000C2C1, 4'b0011, 1'b1);
    idle(1);

    // Backpressure
    out_ready = 1'b0;
    push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0); push(8'h44, 1'b0);
    in_data = 8'h55; in_valid = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold", out_data, 32'h44332211);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_drained", {31'd0, out_valid}, 32'd0);
    push(8'h66, 1'b0); push(8'h77, 1'b0); push(8'h88, 1'b0);
    chk_word("bp_next", 32'h88776655, 4'b1111, 1'b0);
    idle(1);

    // Back-to-back streaming
    for (int i = 0; i < 16; i++) begin
      chk("stream_ready", {31'd0, in_ready}, 32'd1);
      push(8'(i), 1'b0);
      if ((i % 4) == 3) begin
        chk("stream_word", out_data, stream_exp[i/4]);
        chk("stream_valid", {31'd0, out_valid}, 32'd1);
      end
    end
    idle(1);

    // Reset mid-word with a stale word still in the output register
    push(8'h11, 1'b0); push(8'h22, 1'b0);
    rst = 1'b1;
    #2;
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_data", out_data, 32'd0);
    chk("mrst_keep", {28'd0, out_keep}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(8'h33, 1'b0); push(8'h44, 1'b0); push(8'h55, 1'b0);
    chk("mrst_partial", {31'd0, out_valid}, 32'd0);
    push(8'h66, 1'b0);
    chk_word("mrst_word", 32'h66554433, 4'b1111, 1'b0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
